// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one bit_width-wide adder, one step per cycle,
// unsigned or two's-complement operands, full 2*bit_width product plus overflow.
module seq_multiplier #(
  parameter int bit_width = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     signed_mode,
  input  logic [bit_width-1:0]     a,
  input  logic [bit_width-1:0]     b,
  output logic                     busy,
  output logic                     done,
  output logic [2*bit_width-1:0]   result,
  output logic                     overflow
);

  localparam int BW  = bit_width;
  localparam int PW  = 2 * bit_width;
  localparam int CW  = (bit_width > 2) ? $clog2(bit_width) : 1;

  localparam logic [BW-1:0] ONE_BW  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] ONE_PW  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_CW  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_INIT = CW'(BW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // |x| in signed mode; the most negative value wraps onto 2^(bw-1), which is correct unsigned.
  function automatic logic [BW-1:0] magnitude(input logic [BW-1:0] x, input logic is_signed);
    logic [BW-1:0] m;
    if (is_signed && x[BW-1]) begin
      m = ~x + ONE_BW;
    end else begin
      m = x;
    end
    return m;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
    logic [PW-1:0] r;
    if (neg && (p != {PW{1'b0}})) begin
      r = ~p + ONE_PW;
    end else begin
      r = p;
    end
    return r;
  endfunction

  function automatic logic product_overflow(input logic [PW-1:0] r, input logic is_signed);
    logic ovf;
    if (is_signed) begin
      ovf = (r[PW-1:BW-1] != {(BW+1){1'b0}}) && (r[PW-1:BW-1] != {(BW+1){1'b1}});
    end else begin
      ovf = (r[PW-1:BW] != {BW{1'b0}});
    end
    return ovf;
  endfunction

  state_t        state_q, state_d;
  logic [BW-1:0] mcand_q, mcand_d;
  logic [BW-1:0] acc_q, acc_d;
  logic [BW-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          sgn_q, sgn_d;
  logic [PW-1:0] result_q, result_d;
  logic          overflow_q, overflow_d;
  logic          done_q, done_d;

  logic [BW:0]   addend_s;
  logic [BW:0]   sum_s;
  logic [PW-1:0] prod_s;
  logic [PW-1:0] signed_prod_s;

  // Datapath step and next-state selection.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    sgn_d      = sgn_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    if (mplier_q[0]) begin
      addend_s = {1'b0, mcand_q};
    end else begin
      addend_s = {(BW+1){1'b0}};
    end
    sum_s = {1'b0, acc_q} + addend_s;
    // The product after the final shift, formed from this step's sum so DONE can register it directly.
    prod_s        = {sum_s, mplier_q[BW-1:1]};
    signed_prod_s = apply_sign(prod_s, neg_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sgn_d    = signed_mode;
          neg_d    = signed_mode & (a[BW-1] ^ b[BW-1]);
          mcand_d  = magnitude(a, signed_mode);
          mplier_d = magnitude(b, signed_mode);
          acc_d    = {BW{1'b0}};
          cnt_d    = CNT_INIT;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = sum_s[BW:1];
        mplier_d = {sum_s[0], mplier_q[BW-1:1]};
        cnt_d    = cnt_q - ONE_CW;
        if (cnt_q == {CW{1'b0}}) begin
          result_d   = signed_prod_s;
          overflow_d = product_overflow(signed_prod_s, sgn_q);
          state_d    = DONE;
        end else begin
          state_d    = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mcand_q    <= {BW{1'b0}};
      acc_q      <= {BW{1'b0}};
      mplier_q   <= {BW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      neg_q      <= 1'b0;
      sgn_q      <= 1'b0;
      result_q   <= {PW{1'b0}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      sgn_q      <= sgn_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (bit_width = 8) with hand-computed products.
module tb_seq_multiplier;

  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            signed_mode;
  logic [BW-1:0]   a;
  logic [BW-1:0]   b;
  logic            busy;
  logic            done;
  logic [2*BW-1:0] result;
  logic            overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.bit_width(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic sm, input logic [BW-1:0] x, input logic [BW-1:0] y);
    signed_mode = sm;
    a           = x;
    b           = y;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Bounded wait for done; counts cycles elapsed and cycles with busy high.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic sm, input logic [BW-1:0] x,
                        input logic [BW-1:0] y, input logic [15:0] exp_r, input logic exp_o);
    int cyc;
    int bn;
    launch(sm, x, y);
    wait_done(cyc, bn);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bn), 32'd8);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    int cyc;
    int bn;
    int done_cnt;

    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    run_op("s_m3_5", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
    run_op("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000, 1'b1);
    run_op("s_80_01", 1'b1, 8'h80, 8'h01, 16'hFF80, 1'b0);
    run_op("s_00_9c", 1'b1, 8'h00, 8'h9C, 16'h0000, 1'b0);
    run_op("u_0f_11", 1'b0, 8'h0F, 8'h11, 16'h00FF, 1'b0);

    // Back-to-back: second start issued in the DONE cycle of the first.
    launch(1'b0, 8'h03, 8'h05);
    wait_done(cyc, bn);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_result", 32'(result), 32'h000F);
    signed_mode = 1'b0;
    a           = 8'd12;
    b           = 8'd10;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check("b2b_busy_rise", 32'(busy), 32'd1);
    check("b2b_first_hold", 32'(result), 32'h000F);
    wait_done(cyc, bn);
    check("b2b_second_gap", 32'(cyc + 1), 32'd9);
    check("b2b_second_result", 32'(result), 32'h0078);
    check("b2b_second_overflow", 32'(overflow), 32'd0);
    tick();
    check("b2b_done_pulse", 32'(done), 32'd0);

    // A start pulsed mid-RUN with different operands must be ignored.
    launch(1'b1, 8'hFD, 8'h05);
    tick();
    tick();
    signed_mode = 1'b0;
    a           = 8'h07;
    b           = 8'h07;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    wait_done(cyc, bn);
    check("ign_latency", 32'(cyc), 32'd5);
    check("ign_result", 32'(result), 32'hFFF1);
    check("ign_overflow", 32'(overflow), 32'd0);
    done_cnt = 0;
    bn       = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) done_cnt++;
      if (busy) bn++;
    end
    check("ign_extra_done", 32'(done_cnt), 32'd0);
    check("ign_extra_busy", 32'(bn), 32'd0);

    // Asynchronous reset in the middle of RUN.
    launch(1'b0, 8'hFF, 8'hFF);
    tick();
    tick();
    tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("u_7_6", 1'b0, 8'h07, 8'h06, 16'h002A, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier with a start/done handshake. It produces the full double-width product in unsigned or two's-complement signed mode, plus an overflow flag that reports when the product does not fit in `bit_width` bits. It serves as the area-lean arithmetic unit for datapaths that can tolerate multi-cycle latency, replacing wide combinational adder trees with one `bit_width`-wide adder and a shift register.

## Interface
- `bit_width`, default 8: operand width, ≥ 2; product width is 2*`bit_width`.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request a multiply; accepted only when `busy`=0.
- `signed_mode` input, 1 bit: 1 = operands are two's complement; 0 = unsigned. Sampled with `start`.
- `a` input, `bit_width` bits: multiplicand, sampled with an accepted `start`.
- `b` input, `bit_width` bits: multiplier, sampled with an accepted `start`.
- `busy` output, 1 bit: operation in progress; `start` is ignored while it is high.
- `done` output, 1 bit: single-cycle pulse; `result` and `overflow` are valid in this cycle.
- `result` output, 2*`bit_width` bits: full product; holds its value until the next accepted start completes.
- `overflow` output, 1 bit: product not representable in `bit_width` bits; held together with `result`.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE with `busy`=0, `done`=0, `result`=0, `overflow`=0, and all internal registers zeroed.
- IDLE/DONE with `start`=1: latch `signed_mode` and operand magnitudes, and latch the result sign `neg` = `signed_mode` & (a[MSB] ^ b[MSB]).
  - Magnitude in signed mode is |x| as a `bit_width`-bit unsigned value. The most negative value -2^(bw-1) maps to 2^(bw-1).
  - Clear the accumulator, load the step counter with `bit_width`-1, and go to RUN.
- RUN, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator. Use a (`bit_width`+1)-bit sum to keep the carry.
  - Shift the {carry, accumulator, multiplier} register right by one.
  - Decrement the counter. After the step with counter = 0, go to DONE.
- DONE entry, same edge as the last RUN step:
  - Register `result` = `neg` ? (two's-complement negate of the magnitude product) : magnitude product. A zero product is never negated.
  - Register `overflow`. Unsigned: result[2bw-1:bw] ≠ 0. Signed: result[2bw-1:bw-1] is not all-zeros and not all-ones.
- DONE lasts one cycle (`done`=1), then the block returns to IDLE unless `start` was accepted in that cycle. In that case it goes directly to RUN.
- `start` while `busy`=1 is ignored. No error is flagged and the operands are not re-sampled.
- Reset asserted mid-operation aborts immediately to the reset state. No `done` is emitted for the aborted operation.

## Timing
- `busy` is combinationally equal to (state == RUN). It is registered via the state and is high for exactly `bit_width` cycles per operation.
- `start` sampled high at edge E0: `busy`=1 from E0 to E0+`bit_width`, and `done`=1 in the cycle after edge E0+`bit_width`.
  - Latency from start to done is `bit_width`+1 cycles.
  - Throughput is one result per `bit_width`+1 cycles with back-to-back starts.
- `result`/`overflow` change only on the edge that enters DONE. They are stable through IDLE and through the following RUN.
- `done` is 0 in every cycle except DONE. It never asserts twice for one accepted start.
- Reset release: the first accepted `start` is the first edge with `rst`=0 and `start`=1.

## Test plan
- `bit_width`=8, unsigned, a=0xFF, b=0xFF → after 9 cycles `done`=1, `result`=0xFE01, `overflow`=1. `busy` is high for exactly 8 cycles.
- Signed, a=0xFD (-3), b=0x05 → `result`=0xFFF1, `overflow`=0. Also a=0x80, b=0x80 → `result`=0x4000, `overflow`=1. Also a=0x80, b=0x01 → `result`=0xFF80, `overflow`=0.
- Zero operands: signed a=0x00, b=0x9C → `result`=0x0000, `overflow`=0, no negation artefact. Also unsigned a=0x0F, b=0x11 → `result`=0x00FF, `overflow`=0.
- Back-to-back: a second `start` asserted in the DONE cycle (unsigned 12×10) → `busy` rises on the next cycle, the second `done` follows 9 cycles after the first, `result`=0x0078. The first result holds until then.
- `start` with different operands pulsed during RUN → ignored. The original product is reported, and only one `done` pulse occurs.
- Assert `rst` asynchronously on cycle 4 of RUN → outputs go to 0 without waiting for a clock edge, and no `done` occurs. A new start after release (7×6 unsigned) gives `result`=0x002A.
